// File: rtl/sys_cmd_ctrl.sv
// Command-frame parser that turns UART RX bytes into register-file and ALU operations and returns results to the UART TX.
// Build option: define SYS_CTRL_ALU_EN to include the 0xCC/0xDD ALU commands and their result path.
module sys_cmd_ctrl #(
  parameter int REG_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [REG_WIDTH-1:0]     i_RX_Data,
  input  logic                     i_RX_Valid,
  output logic                     o_WrEn,
  output logic                     o_RdEn,
  output logic [ADDR_WIDTH-1:0]    o_Address,
  output logic [REG_WIDTH-1:0]     o_WrData,
  input  logic [REG_WIDTH-1:0]     i_RdData,
  input  logic                     i_RdData_Valid,
  output logic                     o_ALU_En,
  output logic [ALU_FUN_WIDTH-1:0] o_ALU_FUN,
  output logic                     o_Clk_Gate_En,
  input  logic [2*REG_WIDTH-1:0]   i_ALU_Out,
  input  logic                     i_ALU_Valid,
  output logic [REG_WIDTH-1:0]     o_TX_Data,
  output logic                     o_TX_Valid,
  input  logic                     i_TX_Busy
);

  // state    | meaning
  // IDLE     | waiting for a command byte
  // WR_ADDR  | write: waiting for address byte
  // WR_DATA  | write: waiting for data byte
  // RD_ADDR  | read: waiting for address byte
  // RD_WAIT  | read issued, waiting for register-file data
  // ALU_A    | ALU: waiting for operand A (stored at address 0)
  // ALU_B    | ALU: waiting for operand B (stored at address 1)
  // ALU_FUN  | ALU: waiting for function byte
  // ALU_WAIT | ALU enabled, waiting for result
  // TX_LO    | sending low byte of ALU result
  // TX_HI    | sending high byte of ALU result
  // TX_RD    | sending register-file read data
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] TX_RD    = 4'd11;
`ifdef SYS_CTRL_ALU_EN
  localparam logic [3:0] ALU_A    = 4'd5;
  localparam logic [3:0] ALU_B    = 4'd6;
  localparam logic [3:0] ALU_FUN  = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_LO    = 4'd9;
  localparam logic [3:0] TX_HI    = 4'd10;
`endif

  localparam logic [REG_WIDTH-1:0] CMD_WR     = REG_WIDTH'(8'hAA);
  localparam logic [REG_WIDTH-1:0] CMD_RD     = REG_WIDTH'(8'hBB);
`ifdef SYS_CTRL_ALU_EN
  localparam logic [REG_WIDTH-1:0] CMD_ALU_OP = REG_WIDTH'(8'hCC);
  localparam logic [REG_WIDTH-1:0] CMD_ALU_NO = REG_WIDTH'(8'hDD);
`endif

  logic [3:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
`ifdef SYS_CTRL_ALU_EN
  logic [REG_WIDTH-1:0]  tx_hi_q;
`endif

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state      <= IDLE;
      addr_q     <= '0;
      o_WrEn     <= 1'b0;
      o_RdEn     <= 1'b0;
      o_Address  <= '0;
      o_WrData   <= '0;
      o_TX_Data  <= '0;
      o_TX_Valid <= 1'b0;
`ifdef SYS_CTRL_ALU_EN
      tx_hi_q       <= '0;
      o_ALU_En      <= 1'b0;
      o_ALU_FUN     <= '0;
      o_Clk_Gate_En <= 1'b0;
`endif
    end else begin
      // register-file strobes are single-cycle by default
      o_WrEn <= 1'b0;
      o_RdEn <= 1'b0;
      case (state)
        IDLE: begin
          if (i_RX_Valid) begin
            case (i_RX_Data)
              CMD_WR:     state <= WR_ADDR;
              CMD_RD:     state <= RD_ADDR;
`ifdef SYS_CTRL_ALU_EN
              CMD_ALU_OP: state <= ALU_A;
              CMD_ALU_NO: state <= ALU_FUN;
`endif
              default:    state <= IDLE;
            endcase
          end
        end
        WR_ADDR: begin
          if (i_RX_Valid) begin
            addr_q <= i_RX_Data[ADDR_WIDTH-1:0];
            state  <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (i_RX_Valid) begin
            o_WrEn    <= 1'b1;
            o_Address <= addr_q;
            o_WrData  <= i_RX_Data;
            state     <= IDLE;
          end
        end
        RD_ADDR: begin
          if (i_RX_Valid) begin
            o_RdEn    <= 1'b1;
            o_Address <= i_RX_Data[ADDR_WIDTH-1:0];
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (i_RdData_Valid) begin
            o_TX_Data  <= i_RdData;
            o_TX_Valid <= 1'b1;
            state      <= TX_RD;
          end
        end
        TX_RD: begin
          if (!i_TX_Busy) begin
            o_TX_Valid <= 1'b0;
            state      <= IDLE;
          end
        end
`ifdef SYS_CTRL_ALU_EN
        ALU_A: begin
          if (i_RX_Valid) begin
            o_WrEn    <= 1'b1;
            o_Address <= '0;
            o_WrData  <= i_RX_Data;
            state     <= ALU_B;
          end
        end
        ALU_B: begin
          if (i_RX_Valid) begin
            o_WrEn    <= 1'b1;
            o_Address <= ADDR_WIDTH'(1);
            o_WrData  <= i_RX_Data;
            state     <= ALU_FUN;
          end
        end
        ALU_FUN: begin
          if (i_RX_Valid) begin
            o_ALU_FUN     <= i_RX_Data[ALU_FUN_WIDTH-1:0];
            o_ALU_En      <= 1'b1;
            o_Clk_Gate_En <= 1'b1;
            state         <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (i_ALU_Valid) begin
            o_ALU_En      <= 1'b0;
            o_Clk_Gate_En <= 1'b0;
            o_TX_Data     <= i_ALU_Out[REG_WIDTH-1:0];
            tx_hi_q       <= i_ALU_Out[2*REG_WIDTH-1:REG_WIDTH];
            o_TX_Valid    <= 1'b1;
            state         <= TX_LO;
          end
        end
        TX_LO: begin
          // hand straight over to the high byte so valid never drops between them
          if (!i_TX_Busy) begin
            o_TX_Data <= tx_hi_q;
            state     <= TX_HI;
          end
        end
        TX_HI: begin
          if (!i_TX_Busy) begin
            o_TX_Valid <= 1'b0;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYS_CTRL_ALU_EN
  assign o_ALU_En      = 1'b0;
  assign o_ALU_FUN     = '0;
  assign o_Clk_Gate_En = 1'b0;

  logic unused_alu;
  assign unused_alu = ^{i_ALU_Out, i_ALU_Valid};
`endif

endmodule
